// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and pixel-store FSM states.
package fb_pkg;

  localparam int unsigned FB_WIDTH         = 320;
  localparam int unsigned FB_HEIGHT        = 200;
  localparam int unsigned FB_BYTES_PER_ROW = FB_WIDTH / 8;
  localparam int unsigned FB_BYTES         = FB_BYTES_PER_ROW * FB_HEIGHT;
  localparam int unsigned FB_ADDR_W        = 13;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD_RD,
    RD_OUT,
    WR_RD,
    WR_MOD
  } fb_state_e;

endpackage

// File: rtl/fb_pixel_store_if.sv
// 1-bit pixel bus between the GPU command engine (master) and the pixel store (slave).
interface fb_pixel_store_if;

  logic [8:0] x_b;
  logic [7:0] y_b;
  logic       read_b;
  logic       write_b;
  logic       in_b;
  logic       out_b;
  logic       rdy_b;

  modport master (
    output x_b, y_b, read_b, write_b, in_b,
    input  out_b, rdy_b
  );

  modport slave (
    input  x_b, y_b, read_b, write_b, in_b,
    output out_b, rdy_b
  );

endinterface

// File: rtl/fb_ram.sv
// Byte-wide synchronous framebuffer RAM; FB_SCANOUT_EN adds a second read-only port.
module fb_ram
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH  = FB_BYTES,
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
`ifdef FB_SCANOUT_EN
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
`endif
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  output logic [7:0]        q
);

  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

`ifdef FB_SCANOUT_EN
  // Scan register is reset so the display sees 0x00 until the first real fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/fb_pixel_store.sv
// Pixel-bus responder: clears the framebuffer after reset, then serves 1-pixel reads
// and read-modify-write pixel writes. Optional scanout port under FB_SCANOUT_EN.
module fb_pixel_store
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT,
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  fb_pixel_store_if.slave   bus
`ifdef FB_SCANOUT_EN
  ,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [7:0]        scan_data
`endif
);

  localparam int unsigned BYTES_PER_ROW = WIDTH / 8;
  localparam int unsigned BYTES         = BYTES_PER_ROW * HEIGHT;

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        bit_q, bit_d;
  logic              din_q, din_d;
  logic              inr_q, inr_d;
  logic              rdy_q, rdy_d;
  logic              out_q, out_d;

  logic [ADDR_W-1:0] req_addr;
  logic              req_inr;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_q;

  // Out-of-range requests are parked on byte 0 so the RAM is never indexed past its end.
  assign req_inr  = (32'(bus.x_b) < WIDTH) && (32'(bus.y_b) < HEIGHT);
  assign req_addr = ADDR_W'(bus.y_b) * ADDR_W'(BYTES_PER_ROW) + ADDR_W'(bus.x_b[8:3]);

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    addr_d    = addr_q;
    bit_d     = bit_q;
    din_d     = din_q;
    inr_d     = inr_q;
    rdy_d     = rdy_q;
    out_d     = out_q;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = ram_q;

    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_q;
        ram_wdata = '0;
        clr_d     = clr_q + ADDR_W'(1);
        if (clr_q == ADDR_W'(BYTES - 1)) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (bus.write_b || bus.read_b) begin
          addr_d  = req_inr ? req_addr : '0;
          bit_d   = bus.x_b[2:0];
          din_d   = bus.in_b;
          inr_d   = req_inr;
          rdy_d   = 1'b0;
          state_d = bus.write_b ? WR_RD : RD_RD;
        end
      end
      RD_RD:  state_d = RD_OUT;
      RD_OUT: begin
        out_d   = inr_q & ram_q[bit_q];
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      WR_RD:  state_d = WR_MOD;
      WR_MOD: begin
        ram_we           = inr_q;
        ram_wdata[bit_q] = din_q;
        rdy_d            = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      addr_q  <= '0;
      bit_q   <= '0;
      din_q   <= 1'b0;
      inr_q   <= 1'b0;
      rdy_q   <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      din_q   <= din_d;
      inr_q   <= inr_d;
      rdy_q   <= rdy_d;
      out_q   <= out_d;
    end
  end

  assign bus.rdy_b = rdy_q;
  assign bus.out_b = out_q;

  fb_ram #(
    .DEPTH  (BYTES),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
`ifdef FB_SCANOUT_EN
    .rst     (rst),
    .rd_addr (scan_addr),
    .rd_data (scan_data),
`endif
    .addr    (ram_addr),
    .we      (ram_we),
    .wdata   (ram_wdata),
    .q       (ram_q)
  );

endmodule
